// File: rtl/spi_req_arbiter_pkg.sv
// Shared types and constants for the SPI request arbiter slice.
//   arb_state_t : arbiter FSM states
//   SPI_DATA_W  : frame width of the attached spi_master (din width)
package spi_req_arbiter_pkg;

  localparam int SPI_DATA_W = 12;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    LAUNCH = 3'd2,
    XFER   = 3'd3,
    DONE   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Bundle of the requester handshake and spi_master handshake signals.
//   master modport : client/environment side (drives requests and cs)
//   slave modport  : arbiter side (drives accept/done/err, newd/din, status)
interface spi_req_arbiter_if
  import spi_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = SPI_DATA_W
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic                      spi_newd;
  logic [DATA_W-1:0]         spi_din;
  logic                      spi_cs;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  modport master (
    output req_valid, req_data, spi_cs,
    input  req_ready, done, err, spi_newd, spi_din, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, spi_cs,
    output req_ready, done, err, spi_newd, spi_din, busy, grant_id
  );

endinterface

// File: rtl/spi_req_arbiter_rr_grant.sv
// Combinational round-robin picker.
//   req : request vector          ptr : highest-priority index this round
//   gnt : one-hot winner          idx : winner index      any : some request set
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand_s;

  // Scan ptr, ptr+1, ... with wrap; the first asserted request wins.
  always_comb begin
    gnt    = {NUM_REQ{1'b0}};
    idx    = {ID_W{1'b0}};
    any    = 1'b0;
    cand_s = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand_s]) begin
        any         = 1'b1;
        idx         = cand_s;
        gnt[cand_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master transmitter among NUM_REQ
// requesters. Latches the granted word, drives newd/din, follows the frame
// via the synchronized cs, and returns one-hot accept/done/err pulses.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_req_arbiter_if.slave (requests, master handshake, status)
module spi_req_arbiter
  import spi_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = SPI_DATA_W,
  parameter int START_TIMEOUT = 63,
  parameter int SYNC_STAGES   = 2
) (
  input logic         clk,
  input logic         rst,
  spi_req_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  arb_state_t             state_r, state_n;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   cs_s;
  logic [ID_W-1:0]        ptr_r, ptr_n;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [NUM_REQ-1:0]     req_ready_r, req_ready_n;
  logic [NUM_REQ-1:0]     done_r, done_n;
  logic [NUM_REQ-1:0]     err_r, err_n;
  logic                   spi_newd_r, spi_newd_n;
  logic [DATA_W-1:0]      spi_din_r, spi_din_n;
  logic [ID_W-1:0]        grant_id_r, grant_id_n;
  logic                   busy_r;

  logic [NUM_REQ-1:0]     rr_gnt_s;
  logic [ID_W-1:0]        rr_idx_s;
  logic                   rr_any_s;
  logic [NUM_REQ-1:0]     gid_oh_s;
  logic [ID_W-1:0]        ptr_inc_s;

  assign cs_s      = cs_sync_r[SYNC_STAGES-1];
  assign gid_oh_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
  assign ptr_inc_s = (rr_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : rr_idx_s + ID_W'(1);

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .req (bus.req_valid),
    .ptr (ptr_r),
    .gnt (rr_gnt_s),
    .idx (rr_idx_s),
    .any (rr_any_s)
  );

  // Next-state and next-output decode for the arbiter FSM.
  always_comb begin
    state_n     = state_r;
    ptr_n       = ptr_r;
    cnt_n       = cnt_r;
    req_ready_n = {NUM_REQ{1'b0}};
    done_n      = {NUM_REQ{1'b0}};
    err_n       = {NUM_REQ{1'b0}};
    spi_newd_n  = spi_newd_r;
    spi_din_n   = spi_din_r;
    grant_id_n  = grant_id_r;
    case (state_r)
      // The counter doubles as a flush delay so the reset value of the
      // synchronizer is not mistaken for an idle master.
      INIT: begin
        if (cs_s && (cnt_r >= CNT_W'(SYNC_STAGES))) begin
          state_n = IDLE;
        end else if (cnt_r < CNT_W'(SYNC_STAGES)) begin
          cnt_n = cnt_r + CNT_W'(1);
        end else begin
          cnt_n = cnt_r;
        end
      end
      IDLE: begin
        if (rr_any_s) begin
          req_ready_n = rr_gnt_s;
          spi_din_n   = bus.req_data[rr_idx_s*DATA_W +: DATA_W];
          grant_id_n  = rr_idx_s;
          ptr_n       = ptr_inc_s;
          cnt_n       = {CNT_W{1'b0}};
          spi_newd_n  = 1'b1;
          state_n     = LAUNCH;
        end else begin
          state_n = IDLE;
        end
      end
      // newd drops as soon as the frame starts so the master does not
      // relaunch when it returns to idle.
      LAUNCH: begin
        if (!cs_s) begin
          spi_newd_n = 1'b0;
          state_n    = XFER;
        end else if (cnt_r == CNT_W'(START_TIMEOUT)) begin
          spi_newd_n = 1'b0;
          err_n      = gid_oh_s;
          state_n    = INIT;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      XFER: begin
        if (cs_s) begin
          state_n = DONE;
        end else begin
          state_n = XFER;
        end
      end
      DONE: begin
        done_n  = gid_oh_s;
        state_n = IDLE;
      end
      default: begin
        spi_newd_n = 1'b0;
        state_n    = INIT;
      end
    endcase
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= INIT;
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      ptr_r       <= {ID_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      req_ready_r <= {NUM_REQ{1'b0}};
      done_r      <= {NUM_REQ{1'b0}};
      err_r       <= {NUM_REQ{1'b0}};
      spi_newd_r  <= 1'b0;
      spi_din_r   <= {DATA_W{1'b0}};
      grant_id_r  <= {ID_W{1'b0}};
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_n;
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.spi_cs};
      ptr_r       <= ptr_n;
      cnt_r       <= cnt_n;
      req_ready_r <= req_ready_n;
      done_r      <= done_n;
      err_r       <= err_n;
      spi_newd_r  <= spi_newd_n;
      spi_din_r   <= spi_din_n;
      grant_id_r  <= grant_id_n;
      busy_r      <= (state_n != IDLE);
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.spi_newd  = spi_newd_r;
  assign bus.spi_din   = spi_din_r;
  assign bus.grant_id  = grant_id_r;
  assign bus.busy      = busy_r;

endmodule
